instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
IF stage of the mips_16 5-stage pipeline. Owns the PC, drives the instruction-memory read address and loads the IF/ID pipeline register. It is the direct consumer of hazard_detection_unit's pipeline_stall_n: on a stall it freezes PC and IF/ID. On a branch taken in EX it redirects PC and flushes IF/ID.

Parameters:
PC_WIDTH, 16, PC and instruction-memory address width (word addressed).
INSTR_WIDTH, 16, instruction width.
OFFSET_WIDTH, 6, branch immediate width (two's complement, in words).
RESET_PC, 16'h0000, PC value after reset.
NOP_INSTR, 16'h0000, instruction loaded into IF/ID on reset or flush.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
pipeline_stall_n  input  1  from hazard_detection_unit; 0 = stall IF and ID.
ex_branch_taken  input  1  branch in EX resolved taken this cycle.
ex_branch_pc  input  PC_WIDTH  PC of the branch instruction now in EX.
ex_branch_offset  input  OFFSET_WIDTH  signed word offset of that branch.
imem_addr  output  PC_WIDTH  instruction-memory read address; equals current PC.
imem_data  input  INSTR_WIDTH  combinational read data for imem_addr.
if_id_instr  output  INSTR_WIDTH  IF/ID register: fetched instruction.
if_id_pc  output  PC_WIDTH  IF/ID register: PC of if_id_instr.
if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
fetch_count  output  16  count of instructions advanced into IF/ID.

Behaviour:
- Reset: on a clock edge with rst=1, set pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_valid=0 and fetch_count=0. Reset has priority over every other input.
- imem_addr = pc (combinational from the register); no extra latency.
- Per-edge priority when rst=0: branch > stall > advance.
- Branch (ex_branch_taken=1, regardless of pipeline_stall_n):
  - pc <= ex_branch_pc + 1 + sign_extend(ex_branch_offset), computed modulo 2^PC_WIDTH.
  - if_id_instr <= NOP_INSTR, if_id_pc <= 0, if_id_valid <= 0.
  - fetch_count unchanged.
  - Killing the wrong-path instruction already in ID is the decode stage's responsibility, not this block's.
- Stall (ex_branch_taken=0, pipeline_stall_n=0): pc, if_id_instr, if_id_pc, if_id_valid and fetch_count all hold. imem_addr therefore stays constant.
- Advance (ex_branch_taken=0, pipeline_stall_n=1):
  - if_id_instr <= imem_data, if_id_pc <= pc, if_id_valid <= 1.
  - pc <= pc + 1, wrapping 0xFFFF -> 0x0000.
  - fetch_count increments by 1 and saturates at 0xFFFF (no wrap).
- Branch-to-fetch latency: the target appears on imem_addr in the cycle after ex_branch_taken. The target instruction reaches IF/ID one cycle later, provided there is no stall.
- Target arithmetic: sign extension of ex_branch_offset to PC_WIDTH, then unsigned add with carry discarded.
- Reset mid-stall or mid-branch: reset wins; the next cycle resumes normal advance from RESET_PC.
- No combinational path from any input to any output except imem_addr, which depends only on the pc register.

Test Plan:
1. Reset: hold rst=1 for 2 edges with random inputs -> imem_addr=0x0000, if_id_valid=0, if_id_instr=0x0000, fetch_count=0.
2. Sequential fetch: imem model returns 0x1000+addr; release reset, run 3 edges -> if_id_pc=2, if_id_instr=0x1002, imem_addr=3, fetch_count=3.
3. Stall: at imem_addr=5, drive pipeline_stall_n=0 for 2 edges -> imem_addr stays 5, if_id_pc stays 4, if_id_instr stays 0x1004, fetch_count stays 5. Release -> next edge gives if_id_pc=5, imem_addr=6.
4. Branch back: ex_branch_taken=1, ex_branch_pc=3, ex_branch_offset=6'b111110 (-2) -> next imem_addr=0x0002, if_id_valid=0, if_id_instr=NOP. One edge later: if_id_pc=2, if_id_instr=0x1002, valid=1.
5. Branch + stall in the same cycle: ex_branch_taken=1, pipeline_stall_n=0, ex_branch_pc=0x0010, offset=+4 -> imem_addr=0x0015 and IF/ID flushed (branch wins).
6. Wrap: branch to ex_branch_pc=0xFFFD, offset 0 -> imem_addr=0xFFFE. Advance twice -> imem_addr=0x0000. Separately, ex_branch_pc=0xFFFF with offset=+1 -> target 0x0001. Preload fetch_count to 0xFFFF (force) and advance -> it stays 0xFFFF.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// IF stage of the mips_16 pipeline: owns the PC, addresses instruction memory
// and loads the IF/ID register, with stall hold and branch redirect/flush.
module instruction_fetch_stage #(
  parameter int                 PC_WIDTH     = 16,
  parameter int                 INSTR_WIDTH  = 16,
  parameter int                 OFFSET_WIDTH = 6,
  parameter logic [PC_WIDTH-1:0]    RESET_PC  = 16'h0000,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = 16'h0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pipeline_stall_n,
  input  logic                    ex_branch_taken,
  input  logic [PC_WIDTH-1:0]     ex_branch_pc,
  input  logic [OFFSET_WIDTH-1:0] ex_branch_offset,
  output logic [PC_WIDTH-1:0]     imem_addr,
  input  logic [INSTR_WIDTH-1:0]  imem_data,
  output logic [INSTR_WIDTH-1:0]  if_id_instr,
  output logic [PC_WIDTH-1:0]     if_id_pc,
  output logic                    if_id_valid,
  output logic [15:0]             fetch_count
);

  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    if_pc_q, if_pc_d;
  logic                   valid_q, valid_d;
  logic [15:0]            count_q, count_d;
  logic [PC_WIDTH-1:0]    offset_ext;
  logic [PC_WIDTH-1:0]    branch_target;

  // Offset is in words; carry out of the add is deliberately dropped.
  assign offset_ext    = {{(PC_WIDTH-OFFSET_WIDTH){ex_branch_offset[OFFSET_WIDTH-1]}},
                          ex_branch_offset};
  assign branch_target = ex_branch_pc + PC_WIDTH'(1) + offset_ext;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    if_pc_d = if_pc_q;
    valid_d = valid_q;
    count_d = count_q;
    if (ex_branch_taken) begin
      pc_d    = branch_target;
      instr_d = NOP_INSTR;
      if_pc_d = '0;
      valid_d = 1'b0;
    end else if (pipeline_stall_n) begin
      pc_d    = pc_q + PC_WIDTH'(1);
      instr_d = imem_data;
      if_pc_d = pc_q;
      valid_d = 1'b1;
      count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      if_pc_q <= '0;
      valid_q <= 1'b0;
      count_q <= 16'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      if_pc_q <= if_pc_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = if_pc_q;
  assign if_id_valid = valid_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed and randomized checks of instruction_fetch_stage against an
// arithmetic reference model of the fetch rules.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipeline_stall_n;
  logic        ex_branch_taken;
  logic [15:0] ex_branch_pc;
  logic [5:0]  ex_branch_offset;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic        if_id_valid;
  logic [15:0] fetch_count;

  int vectors    = 0;
  int miscompares = 0;

  // Reference state
  int m_pc, m_instr, m_ifpc, m_valid, m_cnt;

  always #5 clk = ~clk;

  // Instruction memory image: word at address a holds 0x1000 + a
  always_comb imem_data = 16'h1000 + imem_addr;

  instruction_fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .pipeline_stall_n (pipeline_stall_n),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_pc     (ex_branch_pc),
    .ex_branch_offset (ex_branch_offset),
    .imem_addr        (imem_addr),
    .imem_data        (imem_data),
    .if_id_instr      (if_id_instr),
    .if_id_pc         (if_id_pc),
    .if_id_valid      (if_id_valid),
    .fetch_count      (fetch_count)
  );

  function automatic void model_edge();
    int target;
    if (rst) begin
      m_pc = 0; m_instr = 0; m_ifpc = 0; m_valid = 0; m_cnt = 0;
    end else if (ex_branch_taken) begin
      target  = int'(ex_branch_pc) + 1 + int'($signed(ex_branch_offset));
      m_pc    = target & 32'hFFFF;
      m_instr = 0; m_ifpc = 0; m_valid = 0;
    end else if (pipeline_stall_n) begin
      m_instr = (32'h1000 + m_pc) & 32'hFFFF;
      m_ifpc  = m_pc;
      m_valid = 1;
      m_pc    = (m_pc + 1) % 65536;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".addr"},  imem_addr,          16'(m_pc));
    chk({tag, ".instr"}, if_id_instr,        16'(m_instr));
    chk({tag, ".ifpc"},  if_id_pc,           16'(m_ifpc));
    chk({tag, ".valid"}, {15'd0, if_id_valid}, 16'(m_valid));
    chk({tag, ".cnt"},   fetch_count,        16'(m_cnt));
    $display("%s: addr=%h ifpc=%h instr=%h valid=%0d cnt=%h",
             tag, imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count);
  endtask

  task automatic drive(input logic r, input logic sn, input logic br,
                       input logic [15:0] bpc, input logic [5:0] off);
    rst = r; pipeline_stall_n = sn; ex_branch_taken = br;
    ex_branch_pc = bpc; ex_branch_offset = off;
  endtask

  initial begin
    // 1. Reset held for two edges with random side inputs
    drive(1'b1, 1'($urandom), 1'($urandom), 16'($urandom), 6'($urandom));
    tick();
    drive(1'b1, 1'($urandom), 1'($urandom), 16'($urandom), 6'($urandom));
    tick();
    chk("reset.addr",  imem_addr,   16'h0000);
    chk("reset.valid", {15'd0, if_id_valid}, 16'h0000);
    chk("reset.instr", if_id_instr, 16'h0000);
    chk("reset.cnt",   fetch_count, 16'h0000);
    chk_model("reset");

    // 2. Sequential fetch
    drive(1'b0, 1'b1, 1'b0, 16'h0, 6'h0);
    repeat (3) tick();
    chk("seq.ifpc",  if_id_pc,    16'h0002);
    chk("seq.instr", if_id_instr, 16'h1002);
    chk("seq.addr",  imem_addr,   16'h0003);
    chk("seq.cnt",   fetch_count, 16'h0003);
    chk_model("seq");

    // 3. Stall at address 5
    repeat (2) tick();
    chk("prestall.addr", imem_addr, 16'h0005);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 6'h0);
    repeat (2) tick();
    chk("stall.addr",  imem_addr,   16'h0005);
    chk("stall.ifpc",  if_id_pc,    16'h0004);
    chk("stall.instr", if_id_instr, 16'h1004);
    chk("stall.cnt",   fetch_count, 16'h0005);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 6'h0);
    tick();
    chk("unstall.ifpc", if_id_pc,  16'h0005);
    chk("unstall.addr", imem_addr, 16'h0006);
    chk_model("unstall");

    // 4. Branch back by -2 from PC 3
    drive(1'b0, 1'b1, 1'b1, 16'h0003, 6'b111110);
    tick();
    chk("brback.addr",  imem_addr,   16'h0002);
    chk("brback.valid", {15'd0, if_id_valid}, 16'h0000);
    chk("brback.instr", if_id_instr, 16'h0000);
    chk("brback.cnt",   fetch_count, 16'h0006);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 6'h0);
    tick();
    chk("brtgt.ifpc",  if_id_pc,    16'h0002);
    chk("brtgt.instr", if_id_instr, 16'h1002);
    chk("brtgt.valid", {15'd0, if_id_valid}, 16'h0001);
    chk_model("brtgt");

    // 5. Branch and stall together: branch wins
    drive(1'b0, 1'b0, 1'b1, 16'h0010, 6'd4);
    tick();
    chk("brstall.addr",  imem_addr, 16'h0015);
    chk("brstall.valid", {15'd0, if_id_valid}, 16'h0000);
    chk("brstall.ifpc",  if_id_pc,  16'h0000);
    chk_model("brstall");

    // 6. PC wrap and target wrap
    drive(1'b0, 1'b1, 1'b1, 16'hFFFD, 6'd0);
    tick();
    chk("wrap.addr", imem_addr, 16'hFFFE);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 6'h0);
    repeat (2) tick();
    chk("wrap2.addr", imem_addr, 16'h0000);
    chk("wrap2.ifpc", if_id_pc,  16'hFFFF);
    drive(1'b0, 1'b1, 1'b1, 16'hFFFF, 6'd1);
    tick();
    chk("tgtwrap.addr", imem_addr, 16'h0001);
    chk_model("tgtwrap");

    // Reset asserted during a stall and during a branch
    drive(1'b1, 1'b0, 1'b1, 16'h1234, 6'd7);
    tick();
    chk_model("rstbranch");
    drive(1'b0, 1'b1, 1'b0, 16'h0, 6'h0);
    tick();
    chk("rstresume.addr", imem_addr, 16'h0001);
    chk("rstresume.ifpc", if_id_pc,  16'h0000);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0), 16'($urandom), 6'($urandom));
      tick();
      chk_model($sformatf("rand%0d", i));
    end

    // fetch_count saturation: fill to 0xFFFF then keep advancing
    drive(1'b1, 1'b1, 1'b0, 16'h0, 6'h0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 16'h0, 6'h0);
    repeat (65535) tick();
    chk("sat.fill", fetch_count, 16'hFFFF);
    repeat (3) tick();
    chk("sat.hold", fetch_count, 16'hFFFF);
    chk_model("sat");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
